// File: rtl/pll_lock_supervisor.sv
// PLL reset sequencer and lock qualifier on the free-running reference clock.
// Releases a synchronous system reset only after lock has been stable, and counts lock events.
module pll_lock_supervisor #(
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned PLL_RST_CYCLES = 16,
  parameter int unsigned LOCK_TIMEOUT   = 50000,
  parameter int unsigned STABLE_CYCLES  = 1024,
  parameter int unsigned CNT_W          = 8
) (
  input  logic             refclk,
  input  logic             rst,
  input  logic             pll_locked,
  output logic             pll_rst,
  output logic             sys_rst,
  output logic             ready,
  output logic [CNT_W-1:0] relock_count,
  output logic [CNT_W-1:0] timeout_count
);

  localparam int unsigned TMR_MAX_A = (PLL_RST_CYCLES > LOCK_TIMEOUT) ? PLL_RST_CYCLES : LOCK_TIMEOUT;
  localparam int unsigned TMR_MAX   = (TMR_MAX_A > STABLE_CYCLES) ? TMR_MAX_A : STABLE_CYCLES;
  localparam int unsigned TMR_W     = $clog2(TMR_MAX + 1);

  localparam logic [TMR_W-1:0] C_RST_LAST     = TMR_W'(PLL_RST_CYCLES - 1);
  localparam logic [TMR_W-1:0] C_TIMEOUT_LAST = TMR_W'(LOCK_TIMEOUT - 1);
  localparam logic [TMR_W-1:0] C_STABLE_LAST  = TMR_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] C_CNT_SAT      = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    S_RESET_PLL = 2'd0,
    S_WAIT_LOCK = 2'd1,
    S_STABILIZE = 2'd2,
    S_RUN       = 2'd3
  } state_t;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [SYNC_STAGES-1:0] r_sync;
  logic                   w_locked_s;
  logic [TMR_W-1:0]       r_tmr;
  logic                   w_inc_timeout;
  logic                   w_inc_relock;
  logic                   w_pll_rst_nxt;
  logic                   w_sys_rst_nxt;
  logic                   w_ready_nxt;
  logic                   r_pll_rst;
  logic                   r_sys_rst;
  logic                   r_ready;
  logic [CNT_W-1:0]       r_relock_count;
  logic [CNT_W-1:0]       r_timeout_count;

  // Lock synchronizer: the only sampler of pll_locked
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], pll_locked};
    end
  end

  assign w_locked_s = r_sync[SYNC_STAGES-1];

  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      r_state <= S_RESET_PLL;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_inc_timeout = 1'b0;
    w_inc_relock  = 1'b0;
    case (r_state)
      S_RESET_PLL: begin
        if (r_tmr == C_RST_LAST) w_state_nxt = S_WAIT_LOCK;
      end
      S_WAIT_LOCK: begin
        if (w_locked_s) begin
          w_state_nxt = S_STABILIZE;
        end else if (r_tmr == C_TIMEOUT_LAST) begin
          w_state_nxt   = S_RESET_PLL;
          w_inc_timeout = 1'b1;
        end
      end
      S_STABILIZE: begin
        if (!w_locked_s) begin
          w_state_nxt = S_WAIT_LOCK;
        end else if (r_tmr == C_STABLE_LAST) begin
          w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        if (!w_locked_s) begin
          w_state_nxt  = S_RESET_PLL;
          w_inc_relock = 1'b1;
        end
      end
      default: w_state_nxt = S_RESET_PLL;
    endcase
  end

  // Outputs follow the next state so they switch on the same edge as r_state
  always_comb begin
    w_pll_rst_nxt = 1'b0;
    w_sys_rst_nxt = 1'b1;
    w_ready_nxt   = 1'b0;
    case (w_state_nxt)
      S_RESET_PLL: w_pll_rst_nxt = 1'b1;
      S_RUN: begin
        w_sys_rst_nxt = 1'b0;
        w_ready_nxt   = 1'b1;
      end
      default: ;
    endcase
  end

  // Shared phase timer; idle in RUN, cleared on every transition
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      r_tmr <= '0;
    end else if (w_state_nxt != r_state) begin
      r_tmr <= '0;
    end else if (r_state != S_RUN) begin
      r_tmr <= r_tmr + TMR_W'(1);
    end
  end

  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      r_pll_rst <= 1'b1;
      r_sys_rst <= 1'b1;
      r_ready   <= 1'b0;
    end else begin
      r_pll_rst <= w_pll_rst_nxt;
      r_sys_rst <= w_sys_rst_nxt;
      r_ready   <= w_ready_nxt;
    end
  end

  // Saturating event counters
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      r_relock_count  <= '0;
      r_timeout_count <= '0;
    end else begin
      if (w_inc_relock && (r_relock_count != C_CNT_SAT)) begin
        r_relock_count <= r_relock_count + CNT_W'(1);
      end
      if (w_inc_timeout && (r_timeout_count != C_CNT_SAT)) begin
        r_timeout_count <= r_timeout_count + CNT_W'(1);
      end
    end
  end

  assign pll_rst       = r_pll_rst;
  assign sys_rst       = r_sys_rst;
  assign ready         = r_ready;
  assign relock_count  = r_relock_count;
  assign timeout_count = r_timeout_count;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Scoreboard bench for pll_lock_supervisor: directed lock/loss/timeout/reset sequences
// push cycle-stamped expected outputs; a negedge monitor pops and compares them.
module tb_pll_lock_supervisor;

  localparam int unsigned CNT_W = 2;

  logic             refclk = 1'b0;
  logic             rst;
  logic             pll_locked;
  logic             pll_rst;
  logic             sys_rst;
  logic             ready;
  logic [CNT_W-1:0] relock_count;
  logic [CNT_W-1:0] timeout_count;

  typedef struct {
    int unsigned at_cyc;
    string       name;
    logic [6:0]  exp;
  } exp_t;

  exp_t        sb_q[$];
  int unsigned cyc     = 0;
  int          n_tests = 0;
  int          n_fail  = 0;
  logic        done    = 1'b0;

  pll_lock_supervisor #(
    .SYNC_STAGES   (2),
    .PLL_RST_CYCLES(4),
    .LOCK_TIMEOUT  (100),
    .STABLE_CYCLES (8),
    .CNT_W         (CNT_W)
  ) dut (
    .refclk       (refclk),
    .rst          (rst),
    .pll_locked   (pll_locked),
    .pll_rst      (pll_rst),
    .sys_rst      (sys_rst),
    .ready        (ready),
    .relock_count (relock_count),
    .timeout_count(timeout_count)
  );

  always #5 refclk = ~refclk;

  always @(posedge refclk) cyc <= cyc + 1;

  // Monitor: compare every expectation due at this cycle; stale or leftover ones fail
  always @(negedge refclk) begin
    logic [6:0] act;
    act = {pll_rst, sys_rst, ready, relock_count, timeout_count};
    for (int i = sb_q.size() - 1; i >= 0; i--) begin
      if (done || (sb_q[i].at_cyc <= cyc)) begin
        n_tests++;
        if ((sb_q[i].at_cyc != cyc) || (act !== sb_q[i].exp)) begin
          n_fail++;
          $display("FAIL %s @cyc %0d (due %0d): got pll_rst/sys_rst/ready/relock/timeout=%b want %b",
                   sb_q[i].name, cyc, sb_q[i].at_cyc, act, sb_q[i].exp);
        end
        sb_q.delete(i);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge refclk);
    #1;
  endtask

  // Expect outputs right after the edge 'rel' edges from now
  task automatic expect_at(input int unsigned rel, input string name, input logic pr,
                           input logic sr, input logic rdy, input logic [1:0] rc,
                           input logic [1:0] tc);
    exp_t e;
    e.at_cyc = cyc + rel;
    e.name   = name;
    e.exp    = {pr, sr, rdy, rc, tc};
    sb_q.push_back(e);
  endtask

  // Immediate comparison, no clock edge involved
  task automatic check_now(input string name, input logic pr, input logic sr,
                           input logic rdy, input logic [1:0] rc, input logic [1:0] tc);
    logic [6:0] act;
    logic [6:0] want;
    act  = {pll_rst, sys_rst, ready, relock_count, timeout_count};
    want = {pr, sr, rdy, rc, tc};
    n_tests++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s (immediate) @cyc %0d: got %b want %b", name, cyc, act, want);
    end
  endtask

  initial begin
    rst        = 1'b1;
    pll_locked = 1'b0;
    #1;
    check_now("reset_now", 1, 1, 0, 2'd0, 2'd0);
    tick(3);
    expect_at(0, "reset_hold", 1, 1, 0, 2'd0, 2'd0);
    tick(1);

    // 1: first lock after reset
    rst = 1'b0;
    expect_at(1,  "t1_prst_e1",   1, 1, 0, 2'd0, 2'd0);
    expect_at(3,  "t1_prst_e3",   1, 1, 0, 2'd0, 2'd0);
    expect_at(4,  "t1_prst_fall", 0, 1, 0, 2'd0, 2'd0);
    tick(10);
    pll_locked = 1'b1;
    expect_at(10, "t1_pre_rel",   0, 1, 0, 2'd0, 2'd0);
    expect_at(11, "t1_release",   0, 0, 1, 2'd0, 2'd0);
    tick(11);
    tick(3);

    // 3: loss of lock in RUN, restored 20 cycles later
    pll_locked = 1'b0;
    expect_at(2,  "t3_still_run", 0, 0, 1, 2'd0, 2'd0);
    expect_at(3,  "t3_loss",      1, 1, 0, 2'd1, 2'd0);
    expect_at(6,  "t3_prst_e4",   1, 1, 0, 2'd1, 2'd0);
    expect_at(7,  "t3_prst_fall", 0, 1, 0, 2'd1, 2'd0);
    expect_at(30, "t3_pre_rel",   0, 1, 0, 2'd1, 2'd0);
    expect_at(31, "t3_release",   0, 0, 1, 2'd1, 2'd0);
    tick(20);
    pll_locked = 1'b1;
    tick(11);
    tick(3);

    // 2: glitch during STABILIZE restarts qualification without a PLL reset
    pll_locked = 1'b0;
    expect_at(3,  "t2_loss",      1, 1, 0, 2'd2, 2'd0);
    expect_at(7,  "t2_wait",      0, 1, 0, 2'd2, 2'd0);
    expect_at(13, "t2_stab",      0, 1, 0, 2'd2, 2'd0);
    expect_at(18, "t2_stab5",     0, 1, 0, 2'd2, 2'd0);
    expect_at(24, "t2_requal",    0, 1, 0, 2'd2, 2'd0);
    expect_at(28, "t2_pre_rel",   0, 1, 0, 2'd2, 2'd0);
    expect_at(29, "t2_release",   0, 0, 1, 2'd2, 2'd0);
    tick(10);
    pll_locked = 1'b1;
    tick(6);
    pll_locked = 1'b0;
    tick(2);
    pll_locked = 1'b1;
    tick(11);
    tick(3);

    // 4: no lock for 600 cycles: periodic timeouts, saturating count
    pll_locked = 1'b0;
    expect_at(3,   "t4_loss",     1, 1, 0, 2'd3, 2'd0);
    expect_at(106, "t4_pre_to1",  0, 1, 0, 2'd3, 2'd0);
    expect_at(107, "t4_to1",      1, 1, 0, 2'd3, 2'd1);
    expect_at(110, "t4_prst_e4",  1, 1, 0, 2'd3, 2'd1);
    expect_at(111, "t4_prst_fall",0, 1, 0, 2'd3, 2'd1);
    expect_at(210, "t4_pre_to2",  0, 1, 0, 2'd3, 2'd1);
    expect_at(211, "t4_to2",      1, 1, 0, 2'd3, 2'd2);
    expect_at(314, "t4_pre_to3",  0, 1, 0, 2'd3, 2'd2);
    expect_at(315, "t4_to3",      1, 1, 0, 2'd3, 2'd3);
    expect_at(418, "t4_pre_to4",  0, 1, 0, 2'd3, 2'd3);
    expect_at(419, "t4_sat4",     1, 1, 0, 2'd3, 2'd3);
    expect_at(523, "t4_sat5",     1, 1, 0, 2'd3, 2'd3);
    expect_at(610, "t4_pre_rel",  0, 1, 0, 2'd3, 2'd3);
    expect_at(611, "t4_release",  0, 0, 1, 2'd3, 2'd3);
    tick(600);
    pll_locked = 1'b1;
    tick(11);
    tick(3);

    // 5: asynchronous reset mid-RUN, between edges
    #1;
    rst = 1'b1;
    #1;
    check_now("t5_async_now", 1, 1, 0, 2'd0, 2'd0);
    expect_at(0, "t5_async_rst",  1, 1, 0, 2'd0, 2'd0);
    tick(1);
    expect_at(0, "t5_rst_held",   1, 1, 0, 2'd0, 2'd0);
    tick(1);
    rst = 1'b0;
    expect_at(1,  "t5_prst_e1",   1, 1, 0, 2'd0, 2'd0);
    expect_at(3,  "t5_prst_e3",   1, 1, 0, 2'd0, 2'd0);
    expect_at(4,  "t5_prst_fall", 0, 1, 0, 2'd0, 2'd0);
    expect_at(12, "t5_pre_rel",   0, 1, 0, 2'd0, 2'd0);
    expect_at(13, "t5_release",   0, 0, 1, 2'd0, 2'd0);
    tick(15);

    // Drain: anything still queued is reported by the monitor
    for (int k = 0; (k < 20) && (sb_q.size() != 0); k++) tick(1);
    n_tests++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations never came due", sb_q.size());
    end
    done = 1'b1;
    tick(2);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
